// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer: loads a WIDTH-bit word, emits it one bit per
// accepted beat in the requested order, and counts completed words.
module piso_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             msb_first,
   output logic             in_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   input  logic             sout_ready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);
   // state | meaning
   // IDLE  | no word loaded, waiting for in_valid
   // SHIFT | word loaded, presenting one bit per sout_ready beat

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic             order_msb;
   logic             accept;
   logic             xfer;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      sout       = 1'b0;
      sout_valid = 1'b0;
      sout_last  = 1'b0;
      busy       = 1'b0;
      if (state == SHIFT) begin
         busy       = 1'b1;
         sout_valid = 1'b1;
         sout       = order_msb ? shreg[WIDTH-1] : shreg[0];
         sout_last  = (bit_cnt == LAST_IDX);
      end
      xfer     = sout_valid && sout_ready;
      // A new word may load on the same edge that the last bit leaves.
      in_ready = !reset && (state == IDLE || (sout_last && sout_ready));
      accept   = in_valid && in_ready;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (xfer && sout_last && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         order_msb <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (accept) begin
            shreg     <= in_data;
            bit_cnt   <= '0;
            order_msb <= msb_first;
         end else if (xfer) begin
            shreg   <= order_msb ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (xfer && sout_last) frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench for piso_stream: an 8-bit instance for ordering, stall,
// back-to-back and reset cases, plus a 2-bit/4-bit-counter instance for wrap.
module tb_piso_stream;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid, msb_first, sout_ready;
   logic        in_ready, sout, sout_valid, sout_last, busy;
   logic [15:0] frame_cnt;

   logic [1:0]  w_data;
   logic        w_valid, w_msb, w_sready;
   logic        w_in_ready, w_sout, w_sout_valid, w_sout_last, w_busy;
   logic [3:0]  w_frame_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_frames;
   logic [3:0]  w_exp_frames;
   logic [1:0]  exp_q[$];   // {last, bit}
   logic [1:0]  w_q[$];

   always #5 clk = ~clk;

   piso_stream #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .msb_first(msb_first), .in_ready(in_ready), .sout(sout),
      .sout_valid(sout_valid), .sout_last(sout_last), .sout_ready(sout_ready),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   piso_stream #(.WIDTH(2), .CNT_W(4)) dut_w (
      .clk(clk), .reset(reset), .in_data(w_data), .in_valid(w_valid),
      .msb_first(w_msb), .in_ready(w_in_ready), .sout(w_sout),
      .sout_valid(w_sout_valid), .sout_last(w_sout_last), .sout_ready(w_sready),
      .busy(w_busy), .frame_cnt(w_frame_cnt)
   );

   task automatic push8(input logic [7:0] d, input logic m);
      for (int i = 0; i < 8; i++)
         exp_q.push_back({(i == 7), (m ? d[7-i] : d[i])});
   endtask

   task automatic push2(input logic [1:0] d, input logic m);
      for (int i = 0; i < 2; i++)
         w_q.push_back({(i == 1), (m ? d[1-i] : d[i])});
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0; msb_first = 1'b0; sout_ready = 1'b1;
      w_valid = 1'b0; w_data = '0; w_msb = 1'b0; w_sready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 ||
          busy !== 1'b0 || frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b s=%b v=%b l=%b busy=%b cnt=%0d exp 0,0,0,0,0,0",
                  in_ready, sout, sout_valid, sout_last, busy, frame_cnt);
      end
      reset = 1'b0; exp_frames = '0; w_exp_frames = '0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_order(input logic m);
      int n;
      logic [1:0] e;
      @(negedge clk);
      in_data = 8'hC1; msb_first = m; in_valid = 1'b1; sout_ready = 1'b1;
      push8(8'hC1, m);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         msb_first = $urandom_range(0, 1);
         in_data   = 8'($urandom);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (sout_valid !== 1'b1 || sout !== e[0] || sout_last !== e[1] || in_ready !== e[1]) begin
            errors++;
            $display("FAIL order%0b_bit%0d got v=%b s=%b l=%b r=%b exp 1,%b,%b,%b",
                     m, n, sout_valid, sout, sout_last, in_ready, e[0], e[1], e[1]);
         end
         if (e[1]) exp_frames++;
         n++;
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || sout_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL order%0b_end got left=%0d v=%b busy=%b cnt=%0d exp 0,0,0,%0d",
                  m, exp_q.size(), sout_valid, busy, frame_cnt, exp_frames);
      end
   endtask

   task automatic test_stall();
      int n, popped, stall;
      logic [1:0] e;
      @(negedge clk);
      in_data = 8'hC1; msb_first = 1'b0; in_valid = 1'b1; sout_ready = 1'b1;
      push8(8'hC1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0; popped = 0; stall = 0;
      while (exp_q.size() > 0 && n < 30) begin
         sout_ready = !(popped == 2 && stall < 3);
         if (!sout_ready) stall++;
         #1;
         e = exp_q[0];
         checks++;
         if (sout_valid !== 1'b1 || sout !== e[0] || sout_last !== e[1] ||
             in_ready !== (e[1] && sout_ready)) begin
            errors++;
            $display("FAIL stall_cyc%0d got v=%b s=%b l=%b r=%b exp 1,%b,%b,%b",
                     n, sout_valid, sout, sout_last, in_ready, e[0], e[1], e[1] && sout_ready);
         end
         if (sout_ready) begin
            void'(exp_q.pop_front());
            popped++;
            if (e[1]) exp_frames++;
         end
         n++;
         @(negedge clk);
      end
      sout_ready = 1'b1;
      checks++;
      if (n != 11 || sout_valid !== 1'b0 || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL stall_end got cycles=%0d v=%b cnt=%0d exp 11,0,%0d", n, sout_valid, frame_cnt, exp_frames);
      end
   endtask

   task automatic test_back_to_back();
      int n, popped;
      logic [1:0] e;
      @(negedge clk);
      in_data = 8'hC1; msb_first = 1'b0; in_valid = 1'b1; sout_ready = 1'b1;
      push8(8'hC1, 1'b0);
      @(negedge clk);
      in_data = 8'h96;
      push8(8'h96, 1'b0);
      n = 0; popped = 0;
      while (exp_q.size() > 0 && n < 40) begin
         in_valid = (popped < 8);
         #1;
         e = exp_q.pop_front();
         popped++;
         checks++;
         if (sout_valid !== 1'b1 || sout !== e[0] || sout_last !== e[1] || in_ready !== e[1]) begin
            errors++;
            $display("FAIL b2b_bit%0d got v=%b s=%b l=%b r=%b exp 1,%b,%b,%b",
                     n, sout_valid, sout, sout_last, in_ready, e[0], e[1], e[1]);
         end
         if (e[1]) exp_frames++;
         n++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (n != 16 || sout_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL b2b_end got bits=%0d v=%b r=%b cnt=%0d exp 16,0,1,%0d",
                  n, sout_valid, in_ready, frame_cnt, exp_frames);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [1:0] e;
      @(negedge clk);
      in_data = 8'hC1; msb_first = 1'b0; in_valid = 1'b1; sout_ready = 1'b1;
      push8(8'hC1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (sout_valid !== 1'b1 || sout !== e[0]) begin
            errors++; $display("FAIL rstmid_bit%0d got v=%b s=%b exp 1,%b", i, sout_valid, sout, e[0]);
         end
         @(negedge clk);
      end
      // Reset wins over an offered word and a ready bit on the same edge.
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      exp_q.delete(); exp_frames = '0; w_exp_frames = '0;
      @(negedge clk);
      checks++;
      if (sout_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_flush got v=%b busy=%b cnt=%0d r=%b exp 0,0,0,0", sout_valid, busy, frame_cnt, in_ready);
      end
      reset = 1'b0; in_data = 8'h96;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_ready got %b exp 1", in_ready);
      end
      push8(8'h96, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         e = exp_q.pop_front();
         checks++;
         if (sout_valid !== 1'b1 || sout !== e[0] || sout_last !== e[1]) begin
            errors++;
            $display("FAIL rstmid_new_bit%0d got v=%b s=%b l=%b exp 1,%b,%b", n, sout_valid, sout, sout_last, e[0], e[1]);
         end
         if (e[1]) exp_frames++;
         n++;
         @(negedge clk);
      end
      checks++;
      if (sout_valid !== 1'b0 || frame_cnt !== exp_frames) begin
         errors++; $display("FAIL rstmid_end got v=%b cnt=%0d exp 0,%0d", sout_valid, frame_cnt, exp_frames);
      end
   endtask

   task automatic test_wrap();
      int n, words;
      logic [1:0] e;
      @(negedge clk);
      w_data = 2'($urandom); w_msb = 1'($urandom); w_valid = 1'b1; w_sready = 1'b1;
      push2(w_data, w_msb);
      words = 1;
      @(negedge clk);
      n = 0;
      while (w_q.size() > 0 && n < 60) begin
         e = w_q.pop_front();
         w_valid = e[1] && (words < 16);
         if (w_valid) begin
            w_data = 2'($urandom); w_msb = 1'($urandom);
            push2(w_data, w_msb);
            words++;
         end
         #1;
         checks++;
         if (w_sout_valid !== 1'b1 || w_sout !== e[0] || w_sout_last !== e[1] ||
             w_in_ready !== e[1] || w_frame_cnt !== w_exp_frames) begin
            errors++;
            $display("FAIL wrap_cyc%0d got v=%b s=%b l=%b r=%b cnt=%0d exp 1,%b,%b,%b,%0d",
                     n, w_sout_valid, w_sout, w_sout_last, w_in_ready, w_frame_cnt,
                     e[0], e[1], e[1], w_exp_frames);
         end
         if (e[1]) w_exp_frames = w_exp_frames + 4'd1;
         n++;
         @(negedge clk);
      end
      w_valid = 1'b0;
      checks++;
      if (n != 32 || w_sout_valid !== 1'b0 || w_frame_cnt !== 4'd0 || w_busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_end got bits=%0d v=%b cnt=%0d busy=%b exp 32,0,0,0",
                  n, w_sout_valid, w_frame_cnt, w_busy);
      end
   endtask

   initial begin
      test_reset();
      test_order(1'b0);
      test_order(1'b1);
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range WIDTH >= 2.
REQ-002 Parameter CNT_W, default 16: width of the completed-frame counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  parallel word to serialise.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 msb_first  input  1  bit order for the offered word (1 = MSB first, 0 = LSB first); sampled only on accept.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 sout  output  1  current serial bit.
REQ-010 sout_valid  output  1  sout carries a valid bit.
REQ-011 sout_last  output  1  current bit is the final bit of the word.
REQ-012 sout_ready  input  1  downstream consumes sout this cycle.
REQ-013 busy  output  1  a word is being serialised (state SHIFT).
REQ-014 frame_cnt  output  CNT_W  count of fully transmitted words.

Function
REQ-015 States: IDLE and SHIFT; busy = (state == SHIFT).
REQ-016 Accept = in_valid && in_ready; on accept at edge N: shift register <= in_data, bit counter <= 0, order latch <= msb_first, state <= SHIFT.
REQ-017 First bit of an accepted word SHALL appear with sout_valid = 1 in the cycle after edge N (latency 1 cycle).
REQ-018 In SHIFT: sout = shreg[WIDTH-1] when the order latch is 1, else shreg[0]; sout_valid = 1; sout_last = (bit counter == WIDTH-1).
REQ-019 Bit transfer = sout_valid && sout_ready; on transfer: MSB mode shifts left with 0 fill, LSB mode shifts right with 0 fill, bit counter increments.
REQ-020 With sout_ready = 0: shreg, counter, sout, sout_last held unchanged (no bit loss, no duplication).
REQ-021 in_ready = !reset && (state == IDLE || (sout_last && sout_ready)).
REQ-022 Transfer of the last bit: frame_cnt increments by 1, wrapping from 2^CNT_W-1 to 0; if in_valid is also high, next word loads at the same edge (back-to-back, no idle cycle); else state <= IDLE.
REQ-023 In IDLE: sout_valid = 0, sout_last = 0, sout = 0; in_data and msb_first are ignored unless accepted.
REQ-024 Sustained throughput with in_valid and sout_ready held high: one bit per cycle, WIDTH cycles per word, zero gap between words.
REQ-025 Changes on in_data or msb_first after accept SHALL NOT affect the word in flight.

Reset
REQ-026 While reset = 1 at a rising edge: state <= IDLE, shreg <= 0, bit counter <= 0, order latch <= 0, frame_cnt <= 0.
REQ-027 Reset values of outputs: in_ready = 0 while reset high and 1 in the first cycle after release; sout = 0, sout_valid = 0, sout_last = 0, busy = 0, frame_cnt = 0.
REQ-028 Reset asserted mid-frame SHALL discard the word in flight; no further bits of it appear and frame_cnt does not count it.
REQ-029 Reset has priority over accept and transfer in the same cycle.

Verification
REQ-030 WIDTH=8, msb_first=0, in_data=8'hC1, sout_ready=1 -> sout 1,0,0,0,0,0,1,1 on 8 consecutive cycles, sout_last only on 8th, frame_cnt=1, then IDLE.
REQ-031 Same with msb_first=1 -> sout 1,1,0,0,0,0,0,1; msb_first toggled during the frame has no effect.
REQ-032 8'hC1 LSB-first, sout_ready low for 3 cycles while 3rd bit is presented -> sout=0 and sout_valid=1 held 4 cycles, full sequence otherwise unchanged.
REQ-033 Back-to-back 8'hC1 then 8'h96 (LSB-first), in_valid held -> 16 contiguous sout_valid cycles: 1,0,0,0,0,0,1,1,0,1,1,0,1,0,0,1; in_ready high only in IDLE and on each sout_last cycle; frame_cnt=2.
REQ-034 Reset asserted after 3 bits of 8'hC1 -> sout_valid=0 next cycle, frame_cnt=0, in_ready=1 after release, next word serialised from bit 0.
REQ-035 WIDTH=2, CNT_W=4, 16 words back-to-back -> frame_cnt wraps 15 -> 0 on the 16th sout_last transfer.
